multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM for the next-generation multicycle 32-bit MIPS-subset datapath; replaces the free-standing control inputs on the single-cycle core.
- Sequences fetch/decode/execute over several cycles against a variable-latency unified memory, using a req/ready handshake.
- Drives an iterative mult/div unit using a start/done handshake with a timeout.
- Sits between the instruction register (opcode/funct) and the datapath muxes, register file, memory and ALU.

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, funct field width
ALUC_W, 4, ALU control width
MD_TIMEOUT, 64, max cycles in MDWAIT before error; counter width = $clog2(MD_TIMEOUT+1)

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  OP_W  instr[31:26] from instruction register
funct  in  FUNCT_W  instr[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
md_done  in  1  mult/div unit finished
mem_req  out  1  memory request
iord  out  1  0 = address from pc, 1 = from aluout
mem_write  out  1  store strobe, valid with mem_req
ir_write  out  1  load instruction register
pc_write  out  1  pc update enable (branch-qualified)
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
alu_src_a  out  1  0 = pc, 1 = rs
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = signimm, 11 = signimm<<2
alu_ctrl  out  ALUC_W  ALU operation
pc_src  out  2  00 = alu result, 01 = aluout, 10 = jump target
wb_sel  out  2  00 = aluout, 01 = mem data, 10 = hi, 11 = lo
md_start  out  1  one-cycle start pulse to the mult/div unit
illegal_op  out  1  one-cycle pulse on an undecodable instruction
md_err  out  1  one-cycle pulse on mult/div timeout
state_o  out  4  current state, for debug

Behaviour:
- Reset: state = FETCH; timeout counter = 0. All outputs are 0 while rst is high, except that FETCH decoding is valid once rst drops.
- Outputs are combinational from the state register (Moore). Exceptions: ir_write and pc_write in FETCH are qualified by mem_ready (Mealy).
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00.
  - Hold while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (precomputes branch target). Next state by opcode:
  - LW/SW -> MEMADR
  - R-type -> EXEC
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other opcode -> ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD. LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready; then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, wb_sel=01. Next FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1. Hold until mem_ready; then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct:
  - add -> ADD, sub -> SUB, and -> AND, or -> OR, slt -> SLT; next ALUWB.
  - mult/div: md_start=1, next MDWAIT.
  - mfhi/mflo: next MFWB.
  - any other funct: ILLEGAL.
- ALUWB: reg_write=1, reg_dst=1, wb_sel=00. Next FETCH.
- MDWAIT:
  - Counter increments each cycle.
  - md_done=1 -> FETCH, counter cleared.
  - Counter reaches MD_TIMEOUT with no md_done -> md_err pulse, FETCH.
  - md_done in the same cycle as the timeout: md_done wins, no error.
- MFWB: reg_write=1, reg_dst=1, wb_sel = 10 for mfhi, 11 for mflo. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=SUB, pc_src=01, pc_write=zero. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD. Next ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, wb_sel=00. Next FETCH.
- JUMP: pc_src=10, pc_write=1. Next FETCH.
- ILLEGAL: illegal_op=1, no writes. Next FETCH.
- Reset mid-operation: immediate return to FETCH; no further mem_write or reg_write. An outstanding memory request is abandoned.
- Unencoded state values: next state is FETCH.

Optional Feature:
- Macro MULTDIV_EN.
- Defined: mult, div, mfhi and mflo decode as above; MDWAIT and MFWB exist.
- Undefined: those functs go to ILLEGAL; md_start and md_err are tied 0; wb_sel only ever 00 or 01; the timeout counter is not instantiated.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum
  - opcode constants: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010
  - funct constants: add=100000, sub=100010, and=100100, or=100101, slt=101010, mult=011000, div=011010, mfhi=010000, mflo=010010
  - ALU encodings: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, MULT=1000, DIV=1001
- One sub-module, md_timeout_ctr: a saturating counter with clear and a tc output.

Test Plan:
- LW, mem_ready low for 3 cycles in FETCH -> FETCH held 4 cycles, ir_write/pc_write exactly once; state sequence DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 with wb_sel=01 in MEMWB.
- BEQ with zero=1 then zero=0 -> pc_write=1, pc_src=01 in BRANCH only for zero=1.
- R-type add (funct 100000) -> EXEC alu_ctrl=0010, ALUWB reg_dst=1, 4 cycles total with mem_ready tied 1.
- mult with md_done after 5 cycles -> single md_start pulse, back to FETCH, md_err=0. Repeat with md_done never asserted -> md_err pulse after 64 MDWAIT cycles.
- opcode 111111 -> illegal_op pulse one cycle after DECODE, then FETCH, no writes.
- rst asserted during MEMWR -> state_o = FETCH asynchronously, mem_write=0 immediately.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// instruction opcode/funct fields and ALU operation codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_MDWAIT  = 4'd8,
        S_MFWB    = 4'd9,
        S_BRANCH  = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12,
        S_JUMP    = 4'd13,
        S_ILLEGAL = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;

endpackage

// File: rtl/multicycle_ctrl_md_timeout_ctr.sv
// Saturating cycle counter with synchronous clear; tc flags the incrementing
// cycle in which the count reaches LIMIT.
module md_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tc = inc && (cnt_q >= CW'(LIMIT - 1));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM (Moore, with mem_ready-qualified fetch strobes).
// Define MULTDIV_EN to enable mult/div/mfhi/mflo and the mult/div timeout logic.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OP_W       = 6,
    parameter int FUNCT_W    = 6,
    parameter int ALUC_W     = 4,
    parameter int MD_TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    input  logic               md_done,
    output logic               mem_req,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUC_W-1:0]  alu_ctrl,
    output logic [1:0]         pc_src,
    output logic [1:0]         wb_sel,
    output logic               md_start,
    output logic               illegal_op,
    output logic               md_err,
    output logic [3:0]         state_o
);

    state_t state_q;
    state_t state_d;

`ifdef MULTDIV_EN
    logic md_inc;
    logic md_clr;
    logic md_tc;

    assign md_inc = (state_q == S_MDWAIT);
    assign md_clr = (state_q != S_MDWAIT) || md_done || md_tc;

    md_timeout_ctr #(
        .LIMIT (MD_TIMEOUT)
    ) u_md_timeout_ctr (
        .clock (clock),
        .rst   (rst),
        .clr   (md_clr),
        .inc   (md_inc),
        .tc    (md_tc)
    );
`else
    logic unused_md_done;
    assign unused_md_done = md_done;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_AND;
        pc_src     = 2'b00;
        wb_sel     = 2'b00;
        md_start   = 1'b0;
        illegal_op = 1'b0;
        md_err     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_ILLEGAL;
                case (funct)
                    FN_ADD: begin alu_ctrl = ALU_ADD; state_d = S_ALUWB; end
                    FN_SUB: begin alu_ctrl = ALU_SUB; state_d = S_ALUWB; end
                    FN_AND: begin alu_ctrl = ALU_AND; state_d = S_ALUWB; end
                    FN_OR:  begin alu_ctrl = ALU_OR;  state_d = S_ALUWB; end
                    FN_SLT: begin alu_ctrl = ALU_SLT; state_d = S_ALUWB; end
`ifdef MULTDIV_EN
                    FN_MULT: begin alu_ctrl = ALU_MULT; md_start = 1'b1; state_d = S_MDWAIT; end
                    FN_DIV:  begin alu_ctrl = ALU_DIV;  md_start = 1'b1; state_d = S_MDWAIT; end
                    FN_MFHI, FN_MFLO: state_d = S_MFWB;
`endif
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MULTDIV_EN
            S_MDWAIT: begin
                // A completion arriving on the timeout cycle suppresses the error.
                if (md_done) begin
                    state_d = S_FETCH;
                end else if (md_tc) begin
                    md_err  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MFWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                wb_sel    = (funct == FN_MFLO) ? 2'b11 : 2'b10;
                state_d   = S_FETCH;
            end
`endif
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = zero;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Nothing may strobe while reset is held, including the fetch request.
        if (rst) begin
            mem_req    = 1'b0;
            iord       = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_ctrl   = ALU_AND;
            pc_src     = 2'b00;
            wb_sel     = 2'b00;
            md_start   = 1'b0;
            illegal_op = 1'b0;
            md_err     = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction reference model queues
// the expected control word for every cycle; a negedge monitor compares them.
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

`ifdef MULTDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV = 6'b011010, F_MFHI = 6'b010000, F_MFLO = 6'b010010;
    localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111, A_MULT = 4'b1000, A_DIV = 4'b1001;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, iord, mem_write, ir_write, pc_write, reg_write, reg_dst, alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic [1:0] pc_src, wb_sel;
        logic       md_start, illegal_op, md_err;
    } out_t;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic zero = 1'b0, mem_ready = 1'b0, md_done = 1'b0;
    logic mem_req, iord, mem_write, ir_write, pc_write, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_src, wb_sel;
    logic [3:0] alu_ctrl, state_o;
    logic md_start, illegal_op, md_err;
    out_t got;

    int checks = 0;
    int errors = 0;
    int cur_id = 0;
    logic [5:0] cur_op = '0, cur_fn = '0;
    out_t exp_q[$];
    int   id_q[$];

    multicycle_ctrl dut (
        .clock(clock), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .md_done(md_done), .mem_req(mem_req), .iord(iord),
        .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src), .wb_sel(wb_sel),
        .md_start(md_start), .illegal_op(illegal_op), .md_err(md_err), .state_o(state_o)
    );

    always #5 clock = ~clock;

    assign got = {state_o, mem_req, iord, mem_write, ir_write, pc_write, reg_write, reg_dst,
                  alu_src_a, alu_src_b, alu_ctrl, pc_src, wb_sel, md_start, illegal_op, md_err};

    // Monitor: one expected control word per cycle, compared mid-cycle.
    always @(negedge clock) begin
        out_t e;
        int   id;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL ctl instr=%0d got=%h expected=%h (st got %0d exp %0d)",
                         id, got, e, got.st, e.st);
            end
        end
    end

    task automatic check(input string name, input out_t act, input out_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    function automatic out_t base(input logic [3:0] st);
        out_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t fetch_word(input logic rdy);
        out_t e = base(S_FETCH);
        e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.alu_ctrl = A_ADD;
        e.ir_write = rdy; e.pc_write = rdy;
        return e;
    endfunction

    task automatic drive(input logic mr, input logic md, input logic z, input out_t e);
        @(posedge clock);
        #1;
        opcode = cur_op; funct = cur_fn;
        mem_ready = mr; md_done = md; zero = z;
        exp_q.push_back(e);
        id_q.push_back(cur_id);
    endtask

    // Reference model: expected cycle-by-cycle behaviour of one instruction.
    // mdl: cycle (1..) of MDWAIT on which md_done rises, or -1 for never.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input int mdl, input bit abort_mem);
        out_t e;
        logic [3:0] ms;
        cur_id++;
        cur_op = op; cur_fn = fn;
        for (int i = 0; i < fw; i++) drive(1'b0, rb(), rb(), fetch_word(1'b0));
        drive(1'b1, rb(), rb(), fetch_word(1'b1));
        e = base(S_DECODE); e.alu_src_b = 2'b11; e.alu_ctrl = A_ADD;
        drive(rb(), rb(), rb(), e);
        if (op == T_LW || op == T_SW) begin
            e = base(S_MEMADR); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = A_ADD;
            drive(rb(), rb(), rb(), e);
            ms = (op == T_LW) ? 4'(S_MEMRD) : 4'(S_MEMWR);
            e = base(ms); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = (op == T_SW);
            for (int i = 0; i < mw; i++) drive(1'b0, rb(), rb(), e);
            if (abort_mem) return;
            drive(1'b1, rb(), rb(), e);
            if (op == T_LW) begin
                e = base(S_MEMWB); e.reg_write = 1'b1; e.wb_sel = 2'b01;
                drive(rb(), rb(), rb(), e);
            end
        end else if (op == T_R) begin
            e = base(S_EXEC); e.alu_src_a = 1'b1;
            if (fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR || fn == F_SLT) begin
                e.alu_ctrl = (fn == F_ADD) ? A_ADD : (fn == F_SUB) ? A_SUB :
                             (fn == F_AND) ? A_AND : (fn == F_OR) ? A_OR : A_SLT;
                drive(rb(), rb(), rb(), e);
                e = base(S_ALUWB); e.reg_write = 1'b1; e.reg_dst = 1'b1;
                drive(rb(), rb(), rb(), e);
            end else if (MD && (fn == F_MULT || fn == F_DIV)) begin
                e.alu_ctrl = (fn == F_MULT) ? A_MULT : A_DIV; e.md_start = 1'b1;
                drive(rb(), 1'b0, rb(), e);
                for (int k = 1; k <= 64; k++) begin
                    e = base(S_MDWAIT);
                    e.md_err = (k == 64) && (k != mdl);
                    drive(rb(), (k == mdl), rb(), e);
                    if (k == mdl) break;
                end
            end else if (MD && (fn == F_MFHI || fn == F_MFLO)) begin
                drive(rb(), rb(), rb(), e);
                e = base(S_MFWB); e.reg_write = 1'b1; e.reg_dst = 1'b1;
                e.wb_sel = (fn == F_MFHI) ? 2'b10 : 2'b11;
                drive(rb(), rb(), rb(), e);
            end else begin
                drive(rb(), rb(), rb(), e);
                e = base(S_ILLEGAL); e.illegal_op = 1'b1;
                drive(rb(), rb(), rb(), e);
            end
        end else if (op == T_BEQ) begin
            e = base(S_BRANCH); e.alu_src_a = 1'b1; e.alu_ctrl = A_SUB;
            e.pc_src = 2'b01; e.pc_write = z;
            drive(rb(), rb(), z, e);
        end else if (op == T_ADDI) begin
            e = base(S_ADDIEX); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = A_ADD;
            drive(rb(), rb(), rb(), e);
            e = base(S_ADDIWB); e.reg_write = 1'b1;
            drive(rb(), rb(), rb(), e);
        end else if (op == T_J) begin
            e = base(S_JUMP); e.pc_src = 2'b10; e.pc_write = 1'b1;
            drive(rb(), rb(), rb(), e);
        end else begin
            e = base(S_ILLEGAL); e.illegal_op = 1'b1;
            drive(rb(), rb(), rb(), e);
        end
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return op == T_R || op == T_LW || op == T_SW || op == T_BEQ || op == T_ADDI || op == T_J;
    endfunction

    function automatic bit known_fn(input logic [5:0] fn);
        return fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR || fn == F_SLT ||
               fn == F_MULT || fn == F_DIV || fn == F_MFHI || fn == F_MFLO;
    endfunction

    initial begin
        logic [5:0] rfn [9];
        logic [5:0] op, fn;
        int k;
        rfn = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MULT, F_DIV, F_MFHI, F_MFLO};

        // Reset: every output low, even with mem_ready high in FETCH.
        #12;
        check("reset_outputs", got, '0);
        mem_ready = 1'b1;
        #1;
        check("reset_fetch_strobes", got, '0);
        mem_ready = 1'b0;
        @(negedge clock);
        rst = 1'b0;
        #1;
        check("fetch_after_reset", got, fetch_word(1'b0));

        // Directed cases.
        run_instr(T_LW,   6'd0,   1'b0, 3, 1, 0, 1'b0);
        run_instr(T_BEQ,  6'd0,   1'b1, 0, 0, 0, 1'b0);
        run_instr(T_BEQ,  6'd0,   1'b0, 0, 0, 0, 1'b0);
        run_instr(T_R,    F_ADD,  1'b0, 0, 0, 0, 1'b0);
        run_instr(T_R,    F_MULT, 1'b0, 0, 0, 5, 1'b0);
        run_instr(T_R,    F_MULT, 1'b0, 1, 0, -1, 1'b0);
        run_instr(T_R,    F_DIV,  1'b0, 0, 0, 64, 1'b0);
        run_instr(T_R,    F_MFHI, 1'b0, 0, 0, 0, 1'b0);
        run_instr(T_R,    F_MFLO, 1'b0, 0, 0, 0, 1'b0);
        run_instr(6'b111111, 6'd0, 1'b0, 0, 0, 0, 1'b0);
        run_instr(T_SW,   6'd0,   1'b0, 1, 2, 0, 1'b0);
        run_instr(T_ADDI, 6'd0,   1'b0, 0, 0, 0, 1'b0);
        run_instr(T_J,    6'd0,   1'b0, 2, 0, 0, 1'b0);
        run_instr(T_R,    6'b000001, 1'b0, 0, 0, 0, 1'b0);

        // Randomized instruction stream.
        for (int n = 0; n < 120; n++) begin
            k  = $urandom_range(0, 15);
            fn = 6'($urandom);
            case (k)
                0: op = T_LW;
                1: op = T_SW;
                11: op = T_BEQ;
                12: op = T_ADDI;
                13: op = T_J;
                14: begin
                    op = 6'($urandom);
                    while (legal_op(op)) op = 6'($urandom);
                end
                15: begin
                    op = T_R;
                    while (known_fn(fn)) fn = 6'($urandom);
                end
                default: begin
                    op = T_R;
                    fn = rfn[k - 2];
                end
            endcase
            run_instr(op, fn, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(1, 8), 1'b0);
        end

        // Reset asserted while a store waits for memory.
        run_instr(T_SW, 6'd0, 1'b0, 0, 2, 0, 1'b1);
        @(posedge clock);
        #1;
        checks++;
        if (got.mem_write !== 1'b1 || got.st !== 4'(S_MEMWR)) begin
            errors++;
            $display("FAIL memwr_before_reset got st=%0d mem_write=%b expected st=%0d mem_write=1",
                     got.st, got.mem_write, S_MEMWR);
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_mid_store", got, '0);
        @(negedge clock);
        rst = 1'b0;
        #1;
        check("fetch_after_mid_reset", got, fetch_word(1'b0));
        run_instr(T_ADDI, 6'd0, 1'b0, 1, 0, 0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
